// File: rtl/cv32e40p_register_file_scrub.sv
// Parity-protected register file (3 read / 2 write ports) with a background scrubber,
// a single-entry error record, a sticky overflow flag and a saturating error counter.
// Optional fault-injection port enabled by defining CV32E40P_RF_FAULT_INJ_EN.
module cv32e40p_register_file_scrub #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int FPU            = 0,
  parameter int ZFINX          = 0,
  parameter int SCRUB_INTERVAL = 64,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef CV32E40P_RF_FAULT_INJ_EN
  input  logic                          inj_en_i,
  input  logic [ADDR_WIDTH-1:0]         inj_addr_i,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] inj_bit_i,
`endif
  input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_c_i,
  input  logic [2:0]                    rd_en_i,
  output logic [DATA_WIDTH-1:0]         rdata_a_o,
  output logic [DATA_WIDTH-1:0]         rdata_b_o,
  output logic [DATA_WIDTH-1:0]         rdata_c_o,
  output logic [2:0]                    rd_err_o,
  input  logic [ADDR_WIDTH-1:0]         waddr_a_i,
  input  logic [DATA_WIDTH-1:0]         wdata_a_i,
  input  logic                          we_a_i,
  input  logic [ADDR_WIDTH-1:0]         waddr_b_i,
  input  logic [DATA_WIDTH-1:0]         wdata_b_i,
  input  logic                          we_b_i,
  input  logic                          scrub_en_i,
  output logic                          err_valid_o,
  input  logic                          err_ready_i,
  output logic [ADDR_WIDTH-1:0]         err_addr_o,
  output logic [1:0]                    err_src_o,
  output logic                          err_overflow_o,
  input  logic                          err_clr_i,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o
);

  localparam int NUM_WORDS   = 2 ** (ADDR_WIDTH - 1);
  localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;
  localparam bit FP_PRESENT  = (FPU != 0) && (ZFINX == 0);
  localparam int IVL_W       = $clog2(SCRUB_INTERVAL) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR =
    FP_PRESENT ? ADDR_WIDTH'(2 * NUM_WORDS - 1) : ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_REPORT} scrub_state_t;

  // Word layout: data in [DATA_WIDTH:1], even parity in bit 0.
  logic [DATA_WIDTH:0] regs [NUM_ENTRIES];

  // Address holds real storage: not x0, and not in an absent FP bank.
  function automatic logic addr_present(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (FP_PRESENT || !a[ADDR_WIDTH-1]);
  endfunction

  // ---------------- read ports ----------------
  logic [ADDR_WIDTH-1:0] raddr [3];
  logic [DATA_WIDTH-1:0] rdata [3];
  logic [2:0]            mism;
  logic [2:0]            rd_err;

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;
  assign raddr[2] = raddr_c_i;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic [DATA_WIDTH:0] word;
    logic                valid_addr;
    assign word       = regs[raddr[p]];
    assign valid_addr = addr_present(raddr[p]);
    assign mism[p]    = valid_addr && (^word);
    // Corrupted words are never forwarded, even when the port is not qualified.
    assign rdata[p]   = (valid_addr && !mism[p]) ? word[DATA_WIDTH:1] : '0;
  end

  assign rdata_a_o = rdata[0];
  assign rdata_b_o = rdata[1];
  assign rdata_c_o = rdata[2];
  assign rd_err    = rd_en_i & mism;
  assign rd_err_o  = rd_err;

  // ---------------- storage ----------------
  logic wr_a, wr_b;
  assign wr_a = we_a_i && addr_present(waddr_a_i);
  assign wr_b = we_b_i && addr_present(waddr_b_i);

`ifdef CV32E40P_RF_FAULT_INJ_EN
  logic                inj_ok;
  logic [DATA_WIDTH:0] inj_mask;
  assign inj_ok   = inj_en_i && addr_present(inj_addr_i);
  assign inj_mask = (DATA_WIDTH+1)'(1) << inj_bit_i;
`endif

  // Storage update: injection first, then port A, then port B so later writes win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) regs[i] <= '0;
    end else begin
`ifdef CV32E40P_RF_FAULT_INJ_EN
      if (inj_ok) regs[inj_addr_i] <= regs[inj_addr_i] ^ inj_mask;
`endif
      if (wr_a) regs[waddr_a_i] <= {wdata_a_i, ^wdata_a_i};
      if (wr_b) regs[waddr_b_i] <= {wdata_b_i, ^wdata_b_i};
    end
  end

  // ---------------- scrubber ----------------
  scrub_state_t          state;
  logic [IVL_W-1:0]      ivl;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  scrub_wr_hit, scrub_detect, scrub_req, scrub_taken;
  logic                  cap_ok;

  assign ptr_next     = (ptr == LAST_PTR) ? ADDR_WIDTH'(1) : ptr + 1'b1;
  // A word being rewritten this cycle is not judged on its stale contents.
  assign scrub_wr_hit = (we_a_i && (waddr_a_i == ptr)) || (we_b_i && (waddr_b_i == ptr));
  assign scrub_detect = (state == S_CHECK) && (^regs[ptr]) && !scrub_wr_hit;
  assign scrub_req    = (state == S_REPORT);
  assign cap_ok       = !err_valid_o || err_ready_i;
  assign scrub_taken  = scrub_req && cap_ok && (rd_err == 3'b000);

  // Scrubber walk: wait an interval, check one word, hold in REPORT until recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ivl   <= '0;
      ptr   <= ADDR_WIDTH'(1);
    end else if (!scrub_en_i) begin
      state <= S_IDLE;
      ivl   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_WAIT;
          ivl   <= '0;
        end
        S_WAIT: begin
          if (ivl == IVL_W'(SCRUB_INTERVAL - 2)) begin
            state <= S_CHECK;
            ivl   <= '0;
          end else begin
            ivl <= ivl + 1'b1;
          end
        end
        S_CHECK: begin
          if (scrub_detect) begin
            state <= S_REPORT;
          end else begin
            ptr   <= ptr_next;
            state <= S_WAIT;
          end
        end
        default: begin
          if (scrub_taken) begin
            ptr   <= ptr_next;
            state <= S_WAIT;
          end
        end
      endcase
    end
  end

  // ---------------- error record ----------------
  logic                  rd_any, rd_multi, ovf_set, new_evt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [1:0]            cap_src;

  assign rd_any   = |rd_err;
  assign rd_multi = (rd_err[0] & rd_err[1]) | (rd_err[0] & rd_err[2]) | (rd_err[1] & rd_err[2]);
  // Read errors that miss the record are lost; scrub errors are retried instead.
  assign ovf_set  = rd_any && (!cap_ok || rd_multi);
  assign new_evt  = rd_any || scrub_detect;

  // Fixed priority A > B > C > scrubber for the captured source.
  always_comb begin
    cap_addr = ptr;
    cap_src  = 2'd3;
    if (rd_err[2]) begin cap_addr = raddr_c_i; cap_src = 2'd2; end
    if (rd_err[1]) begin cap_addr = raddr_b_i; cap_src = 2'd1; end
    if (rd_err[0]) begin cap_addr = raddr_a_i; cap_src = 2'd0; end
  end

  // Single-entry record: capture when empty or popped this cycle, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_src_o   <= '0;
    end else if (cap_ok && (rd_any || scrub_req)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= cap_addr;
      err_src_o   <= cap_src;
    end else if (err_valid_o && err_ready_i) begin
      err_valid_o <= 1'b0;
    end
  end

  // Sticky overflow and saturating event counter; clear still admits this cycle's events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_o <= 1'b0;
      err_cnt_o      <= '0;
    end else if (err_clr_i) begin
      err_overflow_o <= ovf_set;
      err_cnt_o      <= {{(ERR_CNT_WIDTH-1){1'b0}}, new_evt};
    end else begin
      if (ovf_set) err_overflow_o <= 1'b1;
      if (new_evt && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_register_file_scrub.sv
// Directed bench for cv32e40p_register_file_scrub: storage, parity errors,
// error record priority/overflow/counter, scrubber walk and reset.
module tb_cv32e40p_register_file_scrub;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int BW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] raddr_a, raddr_b, raddr_c;
  logic [2:0]    rd_en;
  logic [DW-1:0] rdata_a, rdata_b, rdata_c;
  logic [2:0]    rd_err;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          we_a, we_b;
  logic          scrub_en;
  logic          err_valid, err_ready;
  logic [AW-1:0] err_addr;
  logic [1:0]    err_src;
  logic          err_overflow, err_clr;
  logic [CW-1:0] err_cnt;
`ifdef CV32E40P_RF_FAULT_INJ_EN
  logic          inj_en;
  logic [AW-1:0] inj_addr;
  logic [BW-1:0] inj_bit;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cv32e40p_register_file_scrub #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(0), .ZFINX(0),
    .SCRUB_INTERVAL(4), .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CV32E40P_RF_FAULT_INJ_EN
    .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_bit_i(inj_bit),
`endif
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c), .rd_en_i(rd_en),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rdata_c_o(rdata_c), .rd_err_o(rd_err),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .scrub_en_i(scrub_en), .err_valid_o(err_valid), .err_ready_i(err_ready),
    .err_addr_o(err_addr), .err_src_o(err_src), .err_overflow_o(err_overflow),
    .err_clr_i(err_clr), .err_cnt_o(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input int a, input logic [DW-1:0] d);
    if (port == 0) begin we_a = 1'b1; waddr_a = AW'(a); wdata_a = d; end
    else           begin we_b = 1'b1; waddr_b = AW'(a); wdata_b = d; end
    step();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  // Flip one stored bit (bit 0 = parity, bit k = data bit k-1).
  task automatic corrupt(input int a, input int b);
`ifdef CV32E40P_RF_FAULT_INJ_EN
    inj_en = 1'b1; inj_addr = AW'(a); inj_bit = BW'(b);
    step();
    inj_en = 1'b0;
`else
    logic [DW:0] m;
    m = '0;
    m[b] = 1'b1;
    dut.regs[a] = dut.regs[a] ^ m;
    #1;
`endif
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!err_valid && i < budget) begin step(); i++; end
    chk(tag, err_valid, 1'b1);
  endtask

  task automatic wait_cnt(input string tag, input logic [CW-1:0] v, input int budget);
    int i = 0;
    while (err_cnt !== v && i < budget) begin step(); i++; end
    chk(tag, err_cnt, v);
  endtask

  initial begin
    rst_n = 1'b0; raddr_a = '0; raddr_b = '0; raddr_c = '0; rd_en = '0;
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; we_a = 0; we_b = 0;
    scrub_en = 0; err_ready = 0; err_clr = 0;
`ifdef CV32E40P_RF_FAULT_INJ_EN
    inj_en = 0; inj_addr = '0; inj_bit = '0;
`endif
    step(); step();
    chk("rst_valid", err_valid, 0);
    chk("rst_addr", err_addr, 0);
    chk("rst_src", err_src, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_cnt", err_cnt, 0);
    raddr_a = 5; rd_en = 3'b111; #1;
    chk("rst_rdata", rdata_a, 0);
    chk("rst_rderr", rd_err, 0);
    rd_en = 0;
    rst_n = 1'b1;
    step();

    // Basic write / read on all three ports
    wr(0, 5, 32'hDEADBEEF);
    raddr_a = 5; raddr_b = 5; raddr_c = 5; rd_en = 3'b111; #1;
    chk("t1_rda", rdata_a, 32'hDEADBEEF);
    chk("t1_rdb", rdata_b, 32'hDEADBEEF);
    chk("t1_rdc", rdata_c, 32'hDEADBEEF);
    chk("t1_err", rd_err, 0);
    step(); rd_en = 0;
    chk("t1_valid", err_valid, 0);

    // Port B wins on a same-address collision; x0 and absent FP bank read 0
    we_a = 1; waddr_a = 7; wdata_a = 32'h1111_1111;
    we_b = 1; waddr_b = 7; wdata_b = 32'h2222_2222;
    step(); we_a = 0; we_b = 0;
    raddr_a = 7; #1;
    chk("t2_collide", rdata_a, 32'h2222_2222);
    wr(0, 0, 32'h5);
    raddr_a = 0; rd_en = 3'b001; #1;
    chk("t2_x0", rdata_a, 0);
    chk("t2_x0_err", rd_err, 0);
    wr(0, 37, 32'hCAFE);
    raddr_b = 37; rd_en = 3'b010; #1;
    chk("t2_fp", rdata_b, 0);
    chk("t2_fp_err", rd_err, 0);
    rd_en = 0;

    // Single-bit corruption detected on port B
    wr(0, 3, 32'hA5A5A5A5);
    corrupt(3, 4);
    raddr_a = 3; raddr_b = 3; rd_en = 3'b010; #1;
    chk("t3_rdb", rdata_b, 0);
    chk("t3_rda_forced", rdata_a, 0);
    chk("t3_err", rd_err, 3'b010);
    step(); rd_en = 0;
    chk("t3_valid", err_valid, 1);
    chk("t3_addr", err_addr, 3);
    chk("t3_src", err_src, 1);
    chk("t3_cnt", err_cnt, 1);
    chk("t3_ovf", err_overflow, 0);
    err_ready = 1; step(); err_ready = 0;
    chk("t3_pop", err_valid, 0);

    // Overflow, counter, clear, priority
    wr(0, 12, 32'h0000_00FF);
    corrupt(12, 0);
    raddr_b = 3; rd_en = 3'b010; step(); rd_en = 0;
    raddr_a = 3; raddr_c = 12; rd_en = 3'b101; #1;
    chk("t5_err", rd_err, 3'b101);
    step(); rd_en = 0;
    chk("t5_ovf", err_overflow, 1);
    chk("t5_cnt", err_cnt, 3);
    chk("t5_keep_addr", err_addr, 3);
    chk("t5_keep_src", err_src, 1);
    err_clr = 1; step(); err_clr = 0;
    chk("t5_clr_ovf", err_overflow, 0);
    chk("t5_clr_cnt", err_cnt, 0);
    err_clr = 1; raddr_a = 12; rd_en = 3'b001; step(); err_clr = 0; rd_en = 0;
    chk("t5_clr_evt_cnt", err_cnt, 1);
    err_clr = 1; step(); err_clr = 0;
    chk("t5_clr2_cnt", err_cnt, 0);
    chk("t5_clr2_ovf", err_overflow, 0);
    err_ready = 1; step(); err_ready = 0;
    chk("t5_pop", err_valid, 0);
    raddr_a = 12; raddr_c = 3; rd_en = 3'b101; step(); rd_en = 0;
    chk("pri_valid", err_valid, 1);
    chk("pri_src", err_src, 0);
    chk("pri_addr", err_addr, 12);
    chk("pri_ovf", err_overflow, 1);
    chk("pri_cnt", err_cnt, 1);
    err_ready = 1; raddr_b = 3; rd_en = 3'b010; step(); err_ready = 0; rd_en = 0;
    chk("popcap_valid", err_valid, 1);
    chk("popcap_src", err_src, 1);
    chk("popcap_addr", err_addr, 3);
    err_clr = 1; err_ready = 1; step(); err_clr = 0; err_ready = 0;
    chk("t5_end_valid", err_valid, 0);
    chk("t5_end_cnt", err_cnt, 0);
    wr(0, 3, 32'hA5A5A5A5);
    wr(1, 12, 32'h0000_00FF);
    raddr_a = 3; rd_en = 3'b001; #1;
    chk("repair_rd", rdata_a, 32'hA5A5A5A5);
    chk("repair_err", rd_err, 0);
    rd_en = 0;

    // Scrubber: blocked while the record is full, then advances
    wr(0, 9, 32'h1234_5678);
    wr(0, 10, 32'h0F0F_0F0F);
    wr(0, 11, 32'h0000_0003);
    corrupt(9, 0);
    corrupt(10, 7);
    corrupt(11, 32);
    raddr_c = 9; rd_en = 3'b100; step(); rd_en = 0;
    chk("t4_fill_src", err_src, 2);
    chk("t4_fill_cnt", err_cnt, 1);
    scrub_en = 1;
    wait_cnt("t4_scrub_detect", 2, 100);
    step(); step(); step();
    chk("t4_blocked_src", err_src, 2);
    chk("t4_blocked_ovf", err_overflow, 0);
    err_ready = 1; step(); err_ready = 0;
    chk("t4_cap_valid", err_valid, 1);
    chk("t4_cap_src", err_src, 3);
    chk("t4_cap_addr", err_addr, 9);
    err_ready = 1; step(); err_ready = 0;
    chk("t4_pop", err_valid, 0);
    wait_valid("t4_next_to", 20);
    chk("t4_next_addr", err_addr, 10);
    chk("t4_next_src", err_src, 3);
    chk("t4_next_cnt", err_cnt, 3);
    wait_cnt("t4_x11_detect", 4, 30);
    step(); step();
    chk("t4_x11_blocked", err_addr, 10);

    // Reset in the middle of REPORT
    rst_n = 0; #1;
    chk("t6_valid", err_valid, 0);
    chk("t6_cnt", err_cnt, 0);
    chk("t6_ovf", err_overflow, 0);
    chk("t6_addr", err_addr, 0);
    raddr_a = 9; rd_en = 3'b001; #1;
    chk("t6_rdata", rdata_a, 0);
    chk("t6_rderr", rd_err, 0);
    rd_en = 0; scrub_en = 0;
    step();
    rst_n = 1;
    step();
    wr(0, 1, 32'h8000_0001);
    corrupt(1, 32);
    raddr_a = 1; #1;
    chk("t6_forced_zero", rdata_a, 0);
    chk("t6_unqualified", rd_err, 0);
    scrub_en = 1;
    wait_valid("t6_scrub_to", 20);
    chk("t6_ptr1_addr", err_addr, 1);
    chk("t6_ptr1_src", err_src, 3);
    chk("t6_ptr1_cnt", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cv32e40p_register_file_scrub.md
Name: cv32e40p_register_file_scrub

Overview:
Parity-protected flip-flop register file, parametrised in data width and address width. It has 3 combinational read ports and 2 write ports, plus an optional FP bank. Over the plain parity register file it adds:
- per-port read-enable-qualified error detection;
- a background scrubber FSM that walks every stored word;
- a single-entry error record with valid/ready handshake;
- a sticky overflow flag and a saturating error counter.

It sits in the ID stage in place of the integer/FP register file and drives the fault-monitoring logic.

Parameters:
ADDR_WIDTH, 6, address bits; MSB selects the FP bank; words per bank NUM_WORDS = 2**(ADDR_WIDTH-1)
DATA_WIDTH, 32, data bits per word; each stored word is DATA_WIDTH+1 bits including parity
FPU, 0, 1 = FP bank present (when ZFINX=0)
ZFINX, 0, 1 = FP operands come from the integer bank; no FP storage
SCRUB_INTERVAL, 64, cycles between scrub checks; must be >= 2
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
raddr_a_i/raddr_b_i/raddr_c_i  in  ADDR_WIDTH each  read addresses
rd_en_i  in  3  per-port read qualifiers; bit0=a, bit1=b, bit2=c
rdata_a_o/rdata_b_o/rdata_c_o  out  DATA_WIDTH each  read data
rd_err_o  out  3  per-port combinational parity error
waddr_a_i, wdata_a_i, we_a_i  in  ADDR_WIDTH/DATA_WIDTH/1  write port A
waddr_b_i, wdata_b_i, we_b_i  in  ADDR_WIDTH/DATA_WIDTH/1  write port B
scrub_en_i  in  1  scrubber enable
err_valid_o  out  1  error record valid
err_ready_i  in  1  error record consumed
err_addr_o  out  ADDR_WIDTH  address of the recorded error
err_src_o  out  2  error source: 0=A, 1=B, 2=C, 3=scrubber
err_overflow_o  out  1  sticky: an error was dropped while the record was full
err_clr_i  in  1  clears overflow flag and counter
err_cnt_o  out  ERR_CNT_WIDTH  saturating count of error cycles

Behaviour:
Reset and storage:
- Reset: all words {0, parity 0}.
- Reset values of outputs: err_valid_o=0, err_addr_o=0, err_src_o=0, err_overflow_o=0, err_cnt_o=0. Scrubber goes to IDLE with pointer=1.
- Parity is even: stored parity bit = XOR of the stored data bits.
- R0 always reads 0 with no error; writes to R0 are ignored.

Writes:
- Writes take effect on the next clock edge.
- Same address on both ports in one cycle: port B wins.
- FP bank absent (FPU=0 or ZFINX=1): writes with address MSB=1 are dropped. Reads with MSB=1 return 0 with no error.

Reads:
- Read data is combinational from stored data.
- rd_err_o[p] = rd_en_i[p] AND parity mismatch on the addressed word.
- On mismatch, rdata is forced to 0, regardless of rd_en_i.

Scrubber FSM:
- IDLE: entered when scrub_en_i=0; the interval counter is held at 0.
- WAIT: counts SCRUB_INTERVAL-1 cycles, then goes to CHECK.
- CHECK (1 cycle): evaluates parity of the word at the pointer.
  - Check is suppressed if either write port writes that address in the same cycle.
  - Error → REPORT.
  - No error → advance pointer, return to WAIT.
- REPORT: waits until the scrub error is captured into the record, then advances the pointer and returns to WAIT.
- Pointer wraps from the last present word (NUM_WORDS-1, or 2*NUM_WORDS-1 with FP bank) back to 1. FP-bank word 0 (address NUM_WORDS) is included in the walk.
- scrub_en_i falling: any state → IDLE next cycle; the pointer is retained.

Error record:
- Capture happens when the record is empty, or when it is popped in the same cycle (err_valid_o && err_ready_i).
- Priority among simultaneous sources: A > B > C > scrubber.
- Any error event not captured sets err_overflow_o. This includes lower-priority losers and events arriving while the record is full.
- A scrub error blocked in REPORT is retried each cycle and does not set overflow until it is captured.
- Pop: err_valid_o falls on the edge after err_valid_o && err_ready_i, unless a new capture occurs in the same cycle.

Error counter and clear:
- err_cnt_o increments by 1 in each cycle with at least one new error event; it saturates at all-ones.
- err_clr_i clears overflow and counter next cycle. A simultaneous error event still counts: counter becomes 1.

Optional Feature:
Macro CV32E40P_RF_FAULT_INJ_EN.
- Defined: adds ports inj_en_i (1), inj_addr_i (ADDR_WIDTH), inj_bit_i ($clog2(DATA_WIDTH+1)).
  - inj_en_i=1 inverts the selected stored bit at the next edge. Bit 0 is parity.
  - A same-cycle functional write to that address wins; the inversion is then discarded.
  - Injection to R0 or to an absent FP word is ignored.
- Undefined: the ports do not exist and storage is written only by the write ports.

Test Plan:
1. Write x5=0xDEADBEEF via port A, then read x5 on ports a/b/c with rd_en_i=3'b111 → all read 0xDEADBEEF, rd_err_o=0, err_valid_o=0.
2. Same-cycle writes x7: A=0x1111_1111, B=0x2222_2222 → x7 reads 0x2222_2222; write 0x5 to x0 → x0 reads 0.
3. FAULT_INJ_EN: after writing x3=0xA5A5A5A5, inject bit 4 flip; read on port b with rd_en_i[1]=1 → rdata_b_o=0, rd_err_o=3'b010, err_valid_o=1 next cycle with err_addr_o=3, err_src_o=1, err_cnt_o=1.
4. Corrupt x9, SCRUB_INTERVAL=4, scrub_en_i=1, err_ready_i=0 → scrubber reaches x9 and sets err_valid_o with err_src_o=3, err_addr_o=9. Scrubber stays in REPORT while the record is full. Pulse err_ready_i → record clears, and the scrubber advances to 10.
5. With the record full, port A and port C read corrupted words with enables set → err_overflow_o=1, err_cnt_o increments by 1 for that cycle. err_clr_i → overflow=0, cnt=0.
6. Assert rst_n low mid-REPORT with err_valid_o=1 → all words read 0, err_valid_o=0, err_cnt_o=0, scrubber in IDLE with pointer=1.
